// File: rtl/debounce_parity_pkg.sv
// =============================================================================
// debounce_parity_pkg : board timing constants and sizing helper
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

package debounce_parity_pkg;

  localparam int clk_hz_lp          = 12_000_000;
  localparam int debounce_ms_lp     = 1;
  localparam int debounce_cycles_lp = clk_hz_lp / 1000 * debounce_ms_lp;
  localparam int sync_stages_lp     = 2;

  // Counter must hold values up to debounce_cycles-1 without wrapping.
  function automatic int cnt_width_f(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce.sv
// =============================================================================
// sync_debounce : one channel -- synchroniser, stability counter, press/release
// Rev 1.0 : initial release (release pulse under DEBOUNCE_PARITY_RELEASE_EN)
// =============================================================================
`default_nettype none

module sync_debounce
  import debounce_parity_pkg::*;
#(
  parameter int sync_stages_p     = sync_stages_lp,
  parameter int debounce_cycles_p = debounce_cycles_lp
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_async_unsafe_i,
  output logic btn_o,
  output logic btn_next_o,
  output logic press_o
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  ,
  output logic release_o
`endif
);

  localparam int stages_lp = (sync_stages_p < sync_stages_lp) ? sync_stages_lp : sync_stages_p;
  localparam int cnt_w_lp  = cnt_width_f(debounce_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(debounce_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

  logic [stages_lp-1:0] sync_q, sync_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 d_q, d_d;
  logic                 press_q, press_d;
  logic                 sync_s;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  logic                 release_q, release_d;
`endif

  always_comb begin
    sync_d  = {sync_q[stages_lp-2:0], btn_async_unsafe_i};
    sync_s  = sync_q[stages_lp-1];
    cnt_d   = '0;
    d_d     = d_q;
    // Any sample equal to the accepted level discards the partial count.
    if (sync_s != d_q) begin
      if (cnt_q == cnt_max_lp) begin
        d_d = sync_s;
      end else begin
        cnt_d = cnt_q + cnt_one_lp;
      end
    end
    press_d = d_d & ~d_q;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
    release_d = ~d_d & d_q;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      d_q       <= 1'b0;
      press_q   <= 1'b0;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
      release_q <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      press_q   <= press_d;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
      release_q <= release_d;
`endif
    end
  end

  assign btn_o      = d_q;
  assign btn_next_o = d_d;
  assign press_o    = press_q;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  assign release_o  = release_q;
`endif

endmodule

`default_nettype wire

// File: rtl/debounce_parity.sv
// =============================================================================
// debounce_parity : width_p debounced buttons with press pulses and parity
// Rev 1.0 : initial release; DEBOUNCE_PARITY_RELEASE_EN adds release_o
// =============================================================================
`default_nettype none

module debounce_parity
  import debounce_parity_pkg::*;
#(
  parameter int width_p           = 3,
  parameter int sync_stages_p     = sync_stages_lp,
  parameter int debounce_cycles_p = debounce_cycles_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] btn_async_unsafe_i,
  output logic [width_p-1:0] btn_o,
  output logic [width_p-1:0] press_o,
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  output logic [width_p-1:0] release_o,
`endif
  output logic               parity_o
);

  logic [width_p-1:0] btn_next;
  logic               parity_q, parity_d;

  generate
    for (genvar i = 0; i < width_p; i++) begin : g_chan
      sync_debounce #(
        .sync_stages_p     (sync_stages_p),
        .debounce_cycles_p (debounce_cycles_p)
      ) u_sync_debounce (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .btn_async_unsafe_i (btn_async_unsafe_i[i]),
        .btn_o              (btn_o[i]),
        .btn_next_o         (btn_next[i]),
        .press_o            (press_o[i])
`ifdef DEBOUNCE_PARITY_RELEASE_EN
        ,
        .release_o          (release_o[i])
`endif
      );
    end
  endgenerate

  // Parity is taken from the next debounced levels so it lands with btn_o.
  always_comb begin
    parity_d = ^btn_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_parity.sv
// =============================================================================
// tb_debounce_parity : directed scenarios plus random stimulus vs. a level model
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_debounce_parity;

  localparam int W    = 3;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn;
  logic [W-1:0] btn_o;
  logic [W-1:0] press_o;
  logic         parity_o;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  logic [W-1:0] release_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_parity #(
    .width_p           (W),
    .sync_stages_p     (SYNC),
    .debounce_cycles_p (DB)
  ) u_dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .btn_async_unsafe_i (btn),
    .btn_o              (btn_o),
    .press_o            (press_o),
`ifdef DEBOUNCE_PARITY_RELEASE_EN
    .release_o          (release_o),
`endif
    .parity_o           (parity_o)
  );

  // Reference: s lags the pin by SYNC edges; a level flips once the last DB
  // samples of s all disagree with it.
  logic [W-1:0] m_inq[$];
  logic [W-1:0] m_sq[$];
  logic [W-1:0] m_d, m_press;
  logic         m_par;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
  logic [W-1:0] m_rel;
`endif

  task automatic model_clear();
    m_inq.delete();
    m_sq.delete();
    m_d     = '0;
    m_press = '0;
    m_par   = 1'b0;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
    m_rel   = '0;
`endif
  endtask

  task automatic model_step(input logic [W-1:0] in_v);
    logic [W-1:0] s_v, nd;
    m_inq.push_back(in_v);
    if (m_inq.size() > SYNC + 1) void'(m_inq.pop_front());
    s_v = (m_inq.size() == SYNC + 1) ? m_inq[0] : '0;
    m_sq.push_back(s_v);
    if (m_sq.size() > DB) void'(m_sq.pop_front());
    nd = m_d;
    for (int i = 0; i < W; i++) begin
      int run;
      run = 0;
      foreach (m_sq[j]) if (m_sq[j][i] != m_d[i]) run++;
      if (run == DB) nd[i] = ~m_d[i];
    end
    m_press = nd & ~m_d;
`ifdef DEBOUNCE_PARITY_RELEASE_EN
    m_rel   = m_d & ~nd;
`endif
    m_d   = nd;
    m_par = ^nd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else     model_step(btn);
    #1;
  endtask

  task automatic settle();
    btn = '0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 3'b111;
    model_clear();
    #1;
    total++;
    if ({btn_o, press_o, parity_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_noclk: got btn=%b press=%b par=%b want all 0", btn_o, press_o, parity_o);
    end
    repeat (3) tick();
    total++;
    if ({btn_o, press_o, parity_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold: got btn=%b press=%b par=%b want all 0", btn_o, press_o, parity_o);
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (btn_o !== ((e >= 6) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL reset_rel_btn e=%0d: got %b", e, btn_o);
      end
      total++;
      if (press_o !== ((e == 6) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL reset_rel_press e=%0d: got %b", e, press_o);
      end
      total++;
      if (parity_o !== (e >= 6)) begin
        bad++;
        $display("FAIL reset_rel_par e=%0d: got %b", e, parity_o);
      end
    end
  endtask

  task automatic test_clean_press();
    settle();
    btn = 3'b001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (btn_o !== ((e >= 6) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL press_btn e=%0d: got %b", e, btn_o);
      end
      total++;
      if (press_o !== ((e == 6) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL press_pulse e=%0d: got %b", e, press_o);
      end
      total++;
      if (parity_o !== (e >= 6)) begin
        bad++;
        $display("FAIL press_par e=%0d: got %b", e, parity_o);
      end
    end
    btn = 3'b000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (btn_o !== ((e >= 6) ? 3'b000 : 3'b001)) begin
        bad++;
        $display("FAIL release_btn e=%0d: got %b", e, btn_o);
      end
      total++;
      if (press_o !== 3'b000) begin
        bad++;
        $display("FAIL release_nopress e=%0d: got %b", e, press_o);
      end
`ifdef DEBOUNCE_PARITY_RELEASE_EN
      total++;
      if (release_o !== ((e == 6) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL release_pulse e=%0d: got %b", e, release_o);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    int presses;
    settle();
    presses = 0;
    for (int ph = 0; ph < 4; ph++) begin
      btn = (ph % 2 == 0) ? 3'b010 : 3'b000;
      repeat (2) begin
        tick();
        total++;
        if (btn_o !== 3'b000 || press_o !== 3'b000) begin
          bad++;
          $display("FAIL bounce_toggle ph=%0d: got btn=%b press=%b want 000", ph, btn_o, press_o);
        end
      end
    end
    btn = 3'b010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (press_o[1]) presses++;
      total++;
      if (btn_o[1] !== (e >= 6)) begin
        bad++;
        $display("FAIL bounce_hold e=%0d: got btn[1]=%b", e, btn_o[1]);
      end
    end
    total++;
    if (presses != 1) begin
      bad++;
      $display("FAIL bounce_presses: got %0d want 1", presses);
    end
  endtask

  task automatic test_glitch();
    settle();
    btn = 3'b100;
    repeat (3) tick();
    btn = 3'b000;
    for (int e = 0; e < 10; e++) begin
      if (e > 0) tick();
      total++;
      if (btn_o !== 3'b000 || press_o !== 3'b000 || parity_o !== 1'b0) begin
        bad++;
        $display("FAIL glitch e=%0d: got btn=%b press=%b par=%b want 0", e, btn_o, press_o, parity_o);
      end
    end
  endtask

  task automatic test_simultaneous();
    settle();
    btn = 3'b011;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (press_o !== ((e == 6) ? 3'b011 : 3'b000)) begin
        bad++;
        $display("FAIL simul_press e=%0d: got %b", e, press_o);
      end
      total++;
      if (parity_o !== 1'b0) begin
        bad++;
        $display("FAIL simul_par e=%0d: got %b want 0", e, parity_o);
      end
    end
    total++;
    if (btn_o !== 3'b011) begin
      bad++;
      $display("FAIL simul_btn: got %b want 011", btn_o);
    end
  endtask

  task automatic test_reset_mid_count();
    settle();
    btn = 3'b001;
    repeat (4) tick();
    total++;
    if (u_dut.g_chan[0].u_sync_debounce.cnt_q !== 3'd2) begin
      bad++;
      $display("FAIL midcnt_pre: got cnt=%0d want 2", u_dut.g_chan[0].u_sync_debounce.cnt_q);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (u_dut.g_chan[0].u_sync_debounce.cnt_q !== 3'd0 || btn_o !== 3'b000) begin
      bad++;
      $display("FAIL midcnt_clear: got cnt=%0d btn=%b want 0", u_dut.g_chan[0].u_sync_debounce.cnt_q, btn_o);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (press_o !== ((e == 6) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL midcnt_relatency e=%0d: got press=%b", e, press_o);
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({btn_o, press_o, parity_o} !== 7'b0) begin
      bad++;
      $display("FAIL midpulse_clear: got btn=%b press=%b par=%b want 0", btn_o, press_o, parity_o);
    end
    tick();
    btn = 3'b000;
    rst = 1'b0;
  endtask

  task automatic test_random();
    settle();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 4) == 0) btn[i] = ~btn[i];
      tick();
      total++;
      if (btn_o !== m_d || press_o !== m_press || parity_o !== m_par) begin
        bad++;
        $display("FAIL rand c=%0d: got btn=%b press=%b par=%b want btn=%b press=%b par=%b",
                 c, btn_o, press_o, parity_o, m_d, m_press, m_par);
      end
      total++;
      if (parity_o !== ^btn_o) begin
        bad++;
        $display("FAIL rand_inv c=%0d: got par=%b want %b", c, parity_o, ^btn_o);
      end
`ifdef DEBOUNCE_PARITY_RELEASE_EN
      total++;
      if (release_o !== m_rel) begin
        bad++;
        $display("FAIL rand_rel c=%0d: got %b want %b", c, release_o, m_rel);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/debounce_parity.md
# debounce_parity

Parametrised input-conditioning block for the icebreaker board. It takes `width_p` raw, asynchronous, bouncing button inputs and conditions each channel:
- synchronises it to `clk_i`;
- debounces it with a per-channel stability counter.

It presents the clean levels, one-cycle press pulses and their registered XOR-reduction (parity) for driving LEDs. It sits directly behind the top-level button pins and replaces ad-hoc gate logic fed from unsafe inputs.

## Interface
Parameters:
- `width_p`, default 3: number of button channels, ≥1.
- `sync_stages_p`, default 2: synchroniser flops per channel, ≥2.
- `debounce_cycles_p`, default 12000 (1 ms at 12 MHz): consecutive stable cycles required to accept a new level, ≥1.

Ports:
- `clk_i` in 1: single clock, 12 MHz on board.
- `reset_i` in 1: reset, asynchronous and active-high.
- `btn_async_unsafe_i` in `width_p`: raw buttons, active-high, not synchronised, not debounced.
- `btn_o` out `width_p`: debounced level per channel.
- `press_o` out `width_p`: one-cycle pulse per channel on a debounced 0→1 transition.
- `parity_o` out 1: XOR of all bits of `btn_o`.

## Operation
- Each channel has the following stages and state:
  - Synchroniser: `sync_stages_p` flops in series. Output is `s`.
  - Debounced state `d`, driven on `btn_o`.
  - Counter `cnt`. Width is `$clog2(debounce_cycles_p+1)`.
- Per-channel rules on every rising clock edge:
  - `s == d`: `cnt` ← 0.
  - `s != d` and `cnt < debounce_cycles_p-1`: `cnt` ← `cnt+1`.
  - `s != d` and `cnt == debounce_cycles_p-1`: `d` ← `s`, `cnt` ← 0.
- A glitch back to `d` before the threshold clears `cnt`. There is no partial credit and no hysteresis beyond this.
- `press_o[i]` is registered. It is high exactly in the cycle where `btn_o[i]` first reads 1 after reading 0, and low otherwise.
- `parity_o` is registered and updated on the same edge as `btn_o`. Invariant: `parity_o == ^btn_o` in every cycle.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own `press_o` bit in the same cycle. Parity reflects all of them at once, so two simultaneous presses leave parity unchanged.
- `cnt` never exceeds `debounce_cycles_p-1`. It cannot wrap.

## Timing
- Reset values: all synchroniser flops, `cnt`, `btn_o`, `press_o`, `parity_o` (and `release_o`, when compiled in) are 0.
- Reset asserted mid-count or mid-pulse clears everything immediately, with no clock required.
- After deassertion, a button held high produces a normal press with full latency. There is no press suppression.
- Latency: an input that changes and stays stable is sampled at edge 1 and appears on `btn_o`, `press_o` and `parity_o` after edge `sync_stages_p + debounce_cycles_p`.
- Minimum accepted pulse width is `debounce_cycles_p` cycles at `s`. Shorter pulses never reach `btn_o`.
- With `debounce_cycles_p = 1`, a level is accepted on the first edge where `s != d`.

## Configuration
- Macro: `DEBOUNCE_PARITY_RELEASE_EN`.
- Defined: adds output `release_o`, `width_p` bits. It is a one-cycle registered pulse in the cycle `btn_o[i]` first reads 0 after reading 1, and its reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `debounce_parity_pkg`:
  - `clk_hz_lp` = 12_000_000;
  - `debounce_ms_lp` = 1;
  - derived default `debounce_cycles_lp`;
  - minimum `sync_stages_lp` = 2.
- Sub-module `sync_debounce`: one channel containing the synchroniser, counter, `d`, and the press/release pulse flops.
- The top of `debounce_parity` instantiates `width_p` copies in a generate loop and registers the parity.

## Test plan
Bench parameters: `width_p=3`, `sync_stages_p=2`, `debounce_cycles_p=4`.
- Reset: assert `reset_i` with inputs 3'b111 → all outputs 0 while in reset, regardless of clock. Deassert → `btn_o` becomes 3'b111 exactly 6 edges later, with `press_o` = 3'b111 for one cycle and `parity_o` = 1.
- Clean press on channel 0: input 3'b001 held → `btn_o` = 3'b001, `press_o` = 3'b001 and `parity_o` = 1 after edge 6. `press_o` returns to 0 at edge 7.
- Bounce: channel 1 toggles 1,0,1,0 every 2 cycles, then holds 1 → `btn_o[1]` stays 0 during the toggling and rises 6 edges after the final stable 1. Exactly one press pulse.
- Short glitch: channel 2 high for 3 cycles only → `btn_o[2]`, `press_o[2]` and `parity_o` never change.
- Simultaneous: channels 0 and 1 pressed on the same edge from 3'b000 → `press_o` = 3'b011 in one cycle. `parity_o` stays 0.
- Reset mid-count: assert `reset_i` when `cnt` = 2 → outputs and `cnt` are 0 at once. With `DEBOUNCE_PARITY_RELEASE_EN` defined, a release of channel 0 gives `release_o` = 3'b001 for one cycle.
